pipe_stage_buf: RTL and testbench

//  Parametrised successor to the fixed inter-stage latches of the pipeline (mem_wr class).

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_buf_if.sv | 26 ++
 rtl/pipe_data_reg.sv | 41 ++++
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: occupancy codes
// and the NOP payloads each stage uses as its reset/flush value.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int MEM_WR_WIDTH = 64;
  localparam int EX_MEM_WIDTH = 96;

  // NOP payloads: all write-enables (regWr, multWr, ...) clear.
  localparam logic [MEM_WR_WIDTH-1:0] NOP_MEM_WR = {MEM_WR_WIDTH{1'b0}};
  localparam logic [EX_MEM_WIDTH-1:0] NOP_EX_MEM = {EX_MEM_WIDTH{1'b0}};

  function automatic logic occ_is_full(input logic [1:0] occ);
    return (occ == OCC_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and
// occupancy status. The slave modport is the buffer's own view.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 64
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Load-enable payload register with synchronous reset and synchronous clear,
// both returning the register to RESET_VAL.
module pipe_data_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: clear wins over load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = RESET_VAL;
    end else if (ld_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: one main entry plus an optional skid entry so
// that in_ready can be taken straight from a flop.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_buf_if.slave bus
);

  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             out_valid_s;
  logic             in_ready_s;
  logic             acc_s;
  logic             dep_s;
  logic             main_ld_s;
  logic             skid_ld_s;
  logic             main_from_skid_s;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_s;
  logic [WIDTH-1:0] main_in_s;

  assign out_valid_s = (occ_q != OCC_EMPTY);
  assign acc_s       = bus.in_valid & in_ready_s;
  assign dep_s       = out_valid_s & bus.out_ready;

  // Occupancy transitions and register load enables.
  always_comb begin
    occ_d            = occ_q;
    main_ld_s        = 1'b0;
    skid_ld_s        = 1'b0;
    main_from_skid_s = 1'b0;
    if (bus.flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (acc_s) begin
            occ_d     = OCC_ONE;
            main_ld_s = 1'b1;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (acc_s && dep_s) begin
            main_ld_s = 1'b1;
          end else if (acc_s && (SKID != 0)) begin
            occ_d     = OCC_TWO;
            skid_ld_s = 1'b1;
          end else if (dep_s) begin
            occ_d = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (dep_s) begin
            occ_d            = OCC_ONE;
            main_ld_s        = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            occ_d = OCC_TWO;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  // Occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Ready is precomputed from the next occupancy so no comb path reaches upstream.
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= !occ_is_full(occ_d);
        end
      end

      assign in_ready_s = in_ready_q;

      pipe_data_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_skid (
        .clk  (clk),
        .rst_i(rst),
        .clr_i(bus.flush),
        .ld_i (skid_ld_s),
        .d_i  (bus.in_data),
        .q_o  (skid_s)
      );
    end else begin : g_noskid
      assign in_ready_s = !out_valid_s | bus.out_ready;
      assign skid_s     = RESET_VAL;
    end
  endgenerate

  assign main_in_s = main_from_skid_s ? skid_s : bus.in_data;

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst_i(rst),
    .clr_i(bus.flush),
    .ld_i (main_ld_s),
    .d_i  (main_in_s),
    .q_o  (main_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = main_s;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random
// traffic, compared against a queue-based model of the buffer.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_buf_if #(.WIDTH(64))  bus_a ();
  pipe_stage_buf_if #(.WIDTH(64))  bus_b ();
  pipe_stage_buf_if #(.WIDTH(1))   bus_c ();
  pipe_stage_buf_if #(.WIDTH(256)) bus_d ();

  pipe_stage_buf #(.WIDTH(64), .RESET_VAL(64'd0), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .bus(bus_a));
  pipe_stage_buf #(.WIDTH(64), .RESET_VAL(64'd0), .SKID(0)) u_dut_noskid (
    .clk(clk), .rst(rst), .bus(bus_b));
  pipe_stage_buf #(.WIDTH(1), .RESET_VAL(1'b1), .SKID(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .bus(bus_c));
  pipe_stage_buf #(.WIDTH(256), .RESET_VAL({256{1'b1}}), .SKID(1)) u_dut_w256 (
    .clk(clk), .rst(rst), .bus(bus_d));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: index 0 = SKID=1 buffer (capacity 2), index 1 = SKID=0 buffer (capacity 1).
  logic [63:0] mq [2][$];
  logic [63:0] last_out [2];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k, input int cap, input logic iv, input logic [63:0] id,
                            input logic ordy, input logic fl);
    int sz;
    bit rdy;
    sz  = mq[k].size();
    rdy = (cap == 2) ? (sz < 2) : (sz == 0 || ordy);
    if (rst) begin
      mq[k].delete();
      last_out[k] = 64'd0;
    end else if (fl) begin
      mq[k].delete();
      last_out[k] = 64'd0;
    end else begin
      if (sz > 0 && ordy) last_out[k] = mq[k].pop_front();
      if (iv && rdy) mq[k].push_back(id);
    end
  endtask

  task automatic check_model(input int k, input int cap, input logic rdy, input logic vld,
                             input logic [63:0] data, input logic [1:0] occ, input logic ordy);
    int sz;
    logic [63:0] exp_data;
    sz       = mq[k].size();
    exp_data = (sz > 0) ? mq[k][0] : last_out[k];
    check_eq($sformatf("m%0d_in_ready", k), rdy, (cap == 2) ? (sz < 2) : (sz == 0 || ordy));
    check_eq($sformatf("m%0d_out_valid", k), vld, sz > 0);
    check_eq($sformatf("m%0d_out_data", k), data, exp_data);
    check_eq($sformatf("m%0d_occupancy", k), occ, sz);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 2, bus_a.in_valid, bus_a.in_data, bus_a.out_ready, bus_a.flush);
    model_edge(1, 1, bus_b.in_valid, bus_b.in_data, bus_b.out_ready, bus_b.flush);
    #1;
    check_model(0, 2, bus_a.in_ready, bus_a.out_valid, bus_a.out_data, bus_a.occupancy, bus_a.out_ready);
    check_model(1, 1, bus_b.in_ready, bus_b.out_valid, bus_b.out_data, bus_b.occupancy, bus_b.out_ready);
    bus_b.in_valid  = 1'($urandom_range(0, 1));
    bus_b.in_data   = {$urandom(), $urandom()};
    bus_b.out_ready = 1'($urandom_range(0, 1));
    bus_b.flush     = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    last_out[0] = 64'd0;
    last_out[1] = 64'd0;
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = 64'd0; bus_a.out_ready = 1'b1;
    bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = 64'd0; bus_b.out_ready = 1'b1;
    bus_c.flush = 1'b0; bus_c.in_valid = 1'b0; bus_c.in_data = 1'b0;  bus_c.out_ready = 1'b1;
    bus_d.flush = 1'b0; bus_d.in_valid = 1'b0; bus_d.in_data = '0;    bus_d.out_ready = 1'b1;

    // Reset values.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_out_valid", bus_a.out_valid, 1'b0);
    check_eq("rst_occupancy", bus_a.occupancy, OCC_EMPTY);
    check_eq("rst_out_data", bus_a.out_data, 64'd0);
    check_eq("rst_in_ready", bus_a.in_ready, 1'b1);
    check_eq("w1_rst_data", bus_c.out_data, 1'b1);
    check_eq("w256_rst_data", bus_d.out_data, {256{1'b1}});

    // Streaming at full rate, one-cycle latency.
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 64'(i);
      step();
      check_eq("stream_data", bus_a.out_data, 64'(i));
      check_eq("stream_occ", bus_a.occupancy, OCC_ONE);
      check_eq("stream_in_ready", bus_a.in_ready, 1'b1);
    end
    bus_a.in_valid = 1'b0;
    step();

    // Stall fills the skid entry; release drains in order.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 64'hA5;
    step();
    bus_a.in_data   = 64'h5A;
    step();
    bus_a.in_valid  = 1'b0;
    check_eq("stall_occ", bus_a.occupancy, OCC_TWO);
    check_eq("stall_in_ready", bus_a.in_ready, 1'b0);
    check_eq("stall_data", bus_a.out_data, 64'hA5);
    step();
    check_eq("stall_hold_data", bus_a.out_data, 64'hA5);
    bus_a.out_ready = 1'b1;
    step();
    check_eq("drain_data", bus_a.out_data, 64'h5A);
    check_eq("drain_in_ready", bus_a.in_ready, 1'b1);
    step();
    check_eq("drain_empty", bus_a.occupancy, OCC_EMPTY);

    // Flush while full, with a same-cycle push that must be dropped.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 64'h11;
    bus_c.in_valid = 1'b1; bus_c.in_data = 1'b0;  bus_c.out_ready = 1'b0;
    bus_d.in_valid = 1'b1; bus_d.in_data = '0;    bus_d.out_ready = 1'b0;
    step();
    bus_c.in_valid = 1'b0;
    bus_d.in_valid = 1'b0;
    check_eq("w1_loaded", bus_c.out_data, 1'b0);
    check_eq("w256_loaded", bus_d.out_data, 256'd0);
    bus_a.in_data = 64'h22;
    step();
    check_eq("pre_flush_occ", bus_a.occupancy, OCC_TWO);
    bus_a.in_data = 64'h77;
    bus_a.flush = 1'b1;
    bus_c.flush = 1'b1;
    bus_d.flush = 1'b1;
    step();
    bus_a.flush = 1'b0; bus_c.flush = 1'b0; bus_d.flush = 1'b0;
    bus_a.in_valid = 1'b0;
    check_eq("flush_valid", bus_a.out_valid, 1'b0);
    check_eq("flush_occ", bus_a.occupancy, OCC_EMPTY);
    check_eq("flush_data", bus_a.out_data, 64'd0);
    check_eq("flush_in_ready", bus_a.in_ready, 1'b1);
    check_eq("w1_flush_data", bus_c.out_data, 1'b1);
    check_eq("w256_flush_data", bus_d.out_data, {256{1'b1}});
    bus_a.out_ready = 1'b1;
    step();
    check_eq("flush_no_77", bus_a.out_valid, 1'b0);

    // Reset in the middle of a stall.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 64'h33;
    step();
    bus_a.in_data   = 64'h44;
    step();
    bus_a.in_valid  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_valid", bus_a.out_valid, 1'b0);
    check_eq("rst_mid_occ", bus_a.occupancy, OCC_EMPTY);
    check_eq("rst_mid_data", bus_a.out_data, 64'd0);
    check_eq("rst_mid_in_ready", bus_a.in_ready, 1'b1);
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 64'hBEEF;
    bus_a.out_ready = 1'b1;
    step();
    check_eq("post_rst_data", bus_a.out_data, 64'hBEEF);
    check_eq("post_rst_valid", bus_a.out_valid, 1'b1);
    bus_a.in_valid = 1'b0;
    step();

    // Random traffic on both builds.
    for (int n = 0; n < 10000; n++) begin
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_data   = {$urandom(), $urandom()};
      bus_a.out_ready = 1'($urandom_range(0, 2) != 0);
      bus_a.flush     = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
